// File: rtl/agc_loop_initiator_pkg.sv
// Shared types and constants for the AGC loop Wishbone initiator.
package agc_loop_initiator_pkg;

  localparam int SCALE_W  = 17;
  localparam int WB_ADR_W = 8;
  localparam int WB_DAT_W = 32;

  localparam logic [WB_ADR_W-1:0] DEF_SQ_BASE    = 8'h00;
  localparam logic [WB_ADR_W-1:0] DEF_SCALE_BASE = 8'h20;
  localparam logic [WB_ADR_W-1:0] DEF_APPLY_ADDR = 8'h40;
  localparam logic [SCALE_W-1:0]  DEF_SCALE_INIT = 17'h04000;
  localparam logic [SCALE_W-1:0]  SCALE_MAX      = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CALC  = 3'd2,
    ST_WR    = 3'd3,
    ST_APPLY = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // A scale travels on the bus zero-extended into the low bits of a data word.
  function automatic logic [WB_DAT_W-1:0] scale_word(input logic [SCALE_W-1:0] s);
    return {15'b0, s};
  endfunction

endpackage

// File: rtl/agc_loop_initiator_if.sv
// Classic Wishbone single-cycle bus between the initiator and the AGC target.
interface agc_loop_initiator_if;
  import agc_loop_initiator_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [3:0]          sel;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;
  logic                rty;

  modport master (output cyc, stb, we, adr, dat_w, sel,
                  input  dat_r, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/agc_loop_initiator_scale_step.sv
// Saturating one-step scale update: down on a loud channel, up on a quiet one.
module agc_scale_step
  import agc_loop_initiator_pkg::*;
(
  input  logic [SCALE_W-1:0]  scale,
  input  logic [WB_DAT_W-1:0] sq,
  input  logic [WB_DAT_W-1:0] lo,
  input  logic [WB_DAT_W-1:0] hi,
  input  logic [SCALE_W-1:0]  delta,
  output logic [SCALE_W-1:0]  scale_next
);

  logic [SCALE_W:0] sum_s;
  logic [SCALE_W:0] diff_s;

  // One extra bit exposes the carry/borrow used for saturation.
  assign sum_s  = {1'b0, scale} + {1'b0, delta};
  assign diff_s = {1'b0, scale} - {1'b0, delta};

  // Choose direction; the high threshold wins if the thresholds overlap.
  always_comb begin
    scale_next = scale;
    if (sq > hi) begin
      if (diff_s[SCALE_W]) begin
        scale_next = {SCALE_W{1'b0}};
      end else begin
        scale_next = diff_s[SCALE_W-1:0];
      end
    end else if (sq < lo) begin
      if (sum_s[SCALE_W]) begin
        scale_next = SCALE_MAX;
      end else begin
        scale_next = sum_s[SCALE_W-1:0];
      end
    end else begin
      scale_next = scale;
    end
  end

endmodule

// File: rtl/agc_loop_initiator.sv
// Wishbone initiator that sweeps all AGC channels: read square-sum, step the
// scale, write it back, then commit with an APPLY write.
module agc_loop_initiator
  import agc_loop_initiator_pkg::*;
#(
  parameter int                   NCHAN        = 8,
  parameter int                   PERIOD_CLKS  = 100000,
  parameter int                   TIMEOUT_CLKS = 255,
  parameter logic [WB_ADR_W-1:0]  SQ_BASE      = DEF_SQ_BASE,
  parameter logic [WB_ADR_W-1:0]  SCALE_BASE   = DEF_SCALE_BASE,
  parameter logic [WB_ADR_W-1:0]  APPLY_ADDR   = DEF_APPLY_ADDR,
  parameter logic [SCALE_W-1:0]   SCALE_INIT   = DEF_SCALE_INIT
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       enable_i,
  input  logic                       start_i,
  input  logic [SCALE_W-1:0]         scale_delta_i,
  input  logic [WB_DAT_W-1:0]        target_lo_i,
  input  logic [WB_DAT_W-1:0]        target_hi_i,
  agc_loop_initiator_if.master       wb,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fault_o,
  output logic [NCHAN*SCALE_W-1:0]   scale_o
);

  localparam int              CH_W          = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CH_W-1:0] LAST_CH       = CH_W'(NCHAN - 1);
  localparam logic [31:0]     PERIOD_RELOAD = 32'(PERIOD_CLKS - 1);
  localparam logic [31:0]     TMO_LAST      = 32'(TIMEOUT_CLKS - 1);

  state_e              state_r;
  logic                cyc_r;
  logic                we_r;
  logic [WB_ADR_W-1:0] adr_r;
  logic [WB_DAT_W-1:0] wdat_r;
  logic [WB_DAT_W-1:0] sq_r;
  logic                busy_r;
  logic                done_r;
  logic                fault_r;
  logic [31:0]         timer_r;
  logic [31:0]         tmo_r;
  logic [CH_W-1:0]     ch_r;
  logic [SCALE_W-1:0]  next_r;
  logic [SCALE_W-1:0]  scale_r [NCHAN];
  logic [SCALE_W-1:0]  step_s;
  logic                go_s;
  logic                bus_ok_s;
  logic                bus_abort_s;

  agc_scale_step u_step (
    .scale      (scale_r[ch_r]),
    .sq         (sq_r),
    .lo         (target_lo_i),
    .hi         (target_hi_i),
    .delta      (scale_delta_i),
    .scale_next (step_s)
  );

  // A sweep launches from IDLE on start_i or on timer expiry (one sweep if both).
  always_comb begin
    go_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (start_i) begin
        go_s = 1'b1;
      end else if (enable_i && (timer_r == 32'd0)) begin
        go_s = 1'b1;
      end else begin
        go_s = 1'b0;
      end
    end else begin
      go_s = 1'b0;
    end
  end

  // Classify the current bus cycle: err/rty beat ack; silence past the limit aborts.
  always_comb begin
    bus_ok_s    = cyc_r && wb.ack && !wb.err && !wb.rty;
    bus_abort_s = cyc_r && (wb.err || wb.rty || (!wb.ack && (tmo_r == TMO_LAST)));
  end

  // Sweep sequencer; each bus state first spends one idle setup cycle, then holds cyc until termination.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      cyc_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= {WB_ADR_W{1'b0}};
      wdat_r  <= {WB_DAT_W{1'b0}};
      sq_r    <= {WB_DAT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
      timer_r <= PERIOD_RELOAD;
      tmo_r   <= 32'd0;
      ch_r    <= {CH_W{1'b0}};
      next_r  <= {SCALE_W{1'b0}};
      for (int i = 0; i < NCHAN; i++) begin
        scale_r[i] <= SCALE_INIT;
      end
    end else begin
      done_r <= 1'b0;
      if (bus_abort_s) begin
        cyc_r   <= 1'b0;
        fault_r <= 1'b1;
        busy_r  <= 1'b0;
        state_r <= ST_IDLE;
      end else begin
        if (cyc_r && !bus_ok_s) begin
          tmo_r <= tmo_r + 32'd1;
        end
        case (state_r)
          ST_IDLE: begin
            if (go_s) begin
              timer_r <= PERIOD_RELOAD;
              ch_r    <= {CH_W{1'b0}};
              busy_r  <= 1'b1;
              state_r <= ST_RD;
              if (start_i) begin
                fault_r <= 1'b0;
              end
            end else if (enable_i) begin
              timer_r <= timer_r - 32'd1;
            end
          end
          ST_RD: begin
            if (!cyc_r) begin
              cyc_r  <= 1'b1;
              we_r   <= 1'b0;
              adr_r  <= SQ_BASE + WB_ADR_W'(ch_r);
              wdat_r <= {WB_DAT_W{1'b0}};
              tmo_r  <= 32'd0;
            end else if (bus_ok_s) begin
              cyc_r   <= 1'b0;
              sq_r    <= wb.dat_r;
              state_r <= ST_CALC;
            end
          end
          ST_CALC: begin
            next_r  <= step_s;
            state_r <= ST_WR;
          end
          ST_WR: begin
            if (!cyc_r) begin
              cyc_r  <= 1'b1;
              we_r   <= 1'b1;
              adr_r  <= SCALE_BASE + WB_ADR_W'(ch_r);
              wdat_r <= scale_word(next_r);
              tmo_r  <= 32'd0;
            end else if (bus_ok_s) begin
              cyc_r         <= 1'b0;
              scale_r[ch_r] <= next_r;
              if (ch_r == LAST_CH) begin
                state_r <= ST_APPLY;
              end else begin
                ch_r    <= ch_r + CH_W'(1);
                state_r <= ST_RD;
              end
            end
          end
          ST_APPLY: begin
            if (!cyc_r) begin
              cyc_r  <= 1'b1;
              we_r   <= 1'b1;
              adr_r  <= APPLY_ADDR;
              wdat_r <= 32'h0000_0001;
              tmo_r  <= 32'd0;
            end else if (bus_ok_s) begin
              cyc_r   <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            cyc_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign wb.cyc   = cyc_r;
  assign wb.stb   = cyc_r;
  assign wb.we    = we_r;
  assign wb.adr   = adr_r;
  assign wb.dat_w = wdat_r;
  assign wb.sel   = cyc_r ? 4'hF : 4'h0;
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign fault_o  = fault_r;

  for (genvar g = 0; g < NCHAN; g++) begin : g_scale_out
    assign scale_o[g*SCALE_W +: SCALE_W] = scale_r[g];
  end

endmodule
